// File: rtl/pll_clkdiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_clkdiv_ctrl_pkg
// Description : Shared state encoding and ratio constants for the PLL clock
//               divider controller and its counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_clkdiv_ctrl_pkg;

  // Controller states; encoding is fixed so it can be probed externally.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Ratios at or below this value pass the clock straight through (bypass).
  localparam int C_BYPASS_MAX = 1;

endpackage
`default_nettype wire

// File: rtl/pll_div_counter.sv
`default_nettype none
// ============================================================================
// Module      : pll_div_counter
// Description : Modulo-N period counter. Flags the last cycle of a divided
//               period and pre-computes the high-phase compare for the next
//               cycle so the top can register clk_div without extra latency.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_div_counter
  import pll_clkdiv_ctrl_pkg::*;
#(
  parameter int DIV_W = 5
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             run,        // controller is in RUN or DRAIN
  input  logic [DIV_W-1:0] ratio,      // ratio in force this cycle
  input  logic [DIV_W-1:0] ratio_nxt,  // ratio in force next cycle
  output logic [DIV_W-1:0] cnt_nxt,
  output logic             terminal,   // last cycle of the current period
  output logic             high_nxt    // next cycle lies in the high phase
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_bypassed;

  // Bypassed ratios make every cycle a period boundary.
  always_comb begin
    w_bypassed = (ratio <= DIV_W'(C_BYPASS_MAX));
    terminal   = w_bypassed || (r_cnt == (ratio - DIV_W'(1)));
    if (!run || terminal) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = r_cnt + DIV_W'(1);
    end
    // Next period may use a freshly loaded ratio, so compare against it.
    high_nxt = (cnt_nxt < (ratio_nxt >> 1));
  end

  // Period count register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_clkdiv_ctrl
// Description : Divides the PLL output phase into a registered core clock and
//               a first-cycle clock-enable strobe. Ratio changes arrive over a
//               req/ack handshake and take effect only at period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_clkdiv_ctrl
  import pll_clkdiv_ctrl_pkg::*;
#(
  parameter int DIV_W     = 5,
  parameter int RST_RATIO = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             enable,
  input  logic [DIV_W-1:0] cfg_ratio,
  input  logic             cfg_req,
  output logic             cfg_ack,
  output logic             clk_div,
  output logic             clk_en,
  output logic             bypass,
  output logic             active
);

  localparam logic [DIV_W-1:0] C_RST_RATIO  = DIV_W'(RST_RATIO);
  localparam logic             C_RST_BYPASS = (RST_RATIO <= C_BYPASS_MAX);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_ratio;
  logic [DIV_W-1:0] w_ratio_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             w_terminal;
  logic             w_high_nxt;
  logic             w_running;
  logic             w_boundary;
  logic             w_take;
  logic             w_active_nxt;

  pll_div_counter #(
    .DIV_W (DIV_W)
  ) u_counter (
    .clock     (clock),
    .resetb    (resetb),
    .run       (w_running),
    .ratio     (r_ratio),
    .ratio_nxt (w_ratio_nxt),
    .cnt_nxt   (w_cnt_nxt),
    .terminal  (w_terminal),
    .high_nxt  (w_high_nxt)
  );

  // Handshake and next-state decode. A request still high during its own
  // ack cycle is the old request, so it is masked by the registered ack.
  always_comb begin
    w_running   = (r_state != IDLE);
    w_boundary  = w_running && w_terminal;
    w_take      = cfg_req && !cfg_ack && (!w_running || w_boundary);
    w_ratio_nxt = w_take ? cfg_ratio : r_ratio;
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:        w_state_nxt = enable ? RUN : IDLE;
      RUN, DRAIN: begin
        if (enable) begin
          w_state_nxt = RUN;
        end else if (w_boundary) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default:     w_state_nxt = IDLE;
    endcase
    w_active_nxt = (w_state_nxt != IDLE);
  end

  // FSM state, active ratio and all registered outputs, derived from the
  // next-cycle values so outputs line up with the cycle they describe.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= IDLE;
      r_ratio <= C_RST_RATIO;
      cfg_ack <= 1'b0;
      clk_div <= 1'b0;
      clk_en  <= 1'b0;
      bypass  <= C_RST_BYPASS;
      active  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ratio <= w_ratio_nxt;
      cfg_ack <= w_take;
      clk_div <= w_active_nxt && w_high_nxt;
      clk_en  <= w_active_nxt && (w_cnt_nxt == '0);
      bypass  <= (w_ratio_nxt <= DIV_W'(C_BYPASS_MAX));
      active  <= w_active_nxt;
    end
  end

endmodule
`default_nettype wire
